// File: rtl/aes_spi_frontend.sv
// aes_spi_frontend: oversampled SPI slave that loads AES operands, launches the core and shifts the result out
`timescale 1ns/1ps
module aes_spi_frontend #(
   parameter int FRAME_IN    = 256,
   parameter int FRAME_OUT   = 128,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sck,
   input  logic                  sdi,
   input  logic                  load,
   output logic                  sdo,
   output logic                  done,
   output logic                  frame_err,
   output logic [FRAME_IN/2-1:0] key,
   output logic [FRAME_IN/2-1:0] plaintext,
   output logic                  start,
   input  logic                  core_done,
   input  logic [FRAME_OUT-1:0]  cyphertext
);
   localparam int IW = $clog2(FRAME_IN + 2);
   localparam int OW = $clog2(FRAME_OUT + 1);
   localparam logic [IW-1:0] IN_FULL = IW'(FRAME_IN);
   localparam logic [IW-1:0] IN_SAT = IW'(FRAME_IN + 1);
   localparam logic [OW-1:0] OUT_FULL = OW'(FRAME_OUT);
   typedef enum logic [2:0] {IDLE, RECV, LAUNCH, RUN, HOLD} state_t;
   state_t state;
   logic [SYNC_STAGES-1:0] sck_s, sdi_s, load_s;
   logic sck_h, load_h;
   logic [FRAME_IN-1:0] in_shift;
   logic [FRAME_OUT-1:0] out_shift;
   logic [IW-1:0] in_cnt;
   logic [OW-1:0] out_cnt;
   logic sck_rise, load_rise, load_fall, sdi_q;
   // bring the MCU pins into the clk domain and keep one history flop for edge detection
   always_ff @(posedge clk) begin
      if (reset) begin
         sck_s  <= '0;
         sdi_s  <= '0;
         load_s <= '0;
         sck_h  <= 1'b0;
         load_h <= 1'b0;
      end else begin
         sck_s  <= {sck_s[SYNC_STAGES-2:0], sck};
         sdi_s  <= {sdi_s[SYNC_STAGES-2:0], sdi};
         load_s <= {load_s[SYNC_STAGES-2:0], load};
         sck_h  <= sck_s[SYNC_STAGES-1];
         load_h <= load_s[SYNC_STAGES-1];
      end
   end
   assign sck_rise  = sck_s[SYNC_STAGES-1] & ~sck_h;
   assign load_rise = load_s[SYNC_STAGES-1] & ~load_h;
   assign load_fall = ~load_s[SYNC_STAGES-1] & load_h;
   assign sdi_q     = sdi_s[SYNC_STAGES-1];
   assign sdo       = (state == HOLD) & out_shift[FRAME_OUT-1];
   // frame FSM: a load rise always restarts reception, whatever was in progress
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         done      <= 1'b0;
         frame_err <= 1'b0;
         start     <= 1'b0;
         key       <= '0;
         plaintext <= '0;
         in_shift  <= '0;
         out_shift <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
      end else begin
         start <= 1'b0;
         if (load_rise) begin
            state     <= RECV;
            in_cnt    <= '0;
            frame_err <= 1'b0;
            done      <= 1'b0;
         end else begin
            case (state)
               RECV: begin
                  if (load_fall) begin
                     if (in_cnt == IN_FULL) begin
                        {plaintext, key} <= in_shift;
                        start            <= 1'b1;
                        state            <= LAUNCH;
                     end else begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                     end
                  end else if (sck_rise && in_cnt != IN_SAT) begin
                     in_cnt <= in_cnt + 1'b1;
                     if (in_cnt != IN_FULL)
                        in_shift <= {in_shift[FRAME_IN-2:0], sdi_q};
                  end
               end
               LAUNCH: state <= RUN;
               RUN: begin
                  if (core_done) begin
                     out_shift <= cyphertext;
                     out_cnt   <= '0;
                     done      <= 1'b1;
                     state     <= HOLD;
                  end
               end
               HOLD: begin
                  if (sck_rise && out_cnt != OUT_FULL) begin
                     out_shift <= {out_shift[FRAME_OUT-2:0], 1'b0};
                     out_cnt   <= out_cnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule
